// File: rtl/pe_pkg.sv
// pe_pkg: default PE sizes shared with the systolic array top,
// plus the tag carried alongside each product in the multiply pipe.
package pe_pkg;

  localparam int PE_DATA_W     = 8;
  localparam int PE_ACC_W      = 32;
  localparam int PE_MUL_STAGES = 2;

  typedef struct packed {
    logic vld;
    logic last;
  } pe_tag_t;

endpackage

// File: rtl/pe_mac_if.sv
// pe_mac_if: result port of a PE (valid/ready with sum and flags).
// master = PE side (drives vld/data/sat/ovf), slave = consumer (drives rdy).
interface pe_mac_if
  import pe_pkg::*;
#(
  parameter int ACC_W = PE_ACC_W
) ();

  logic             res_vld;
  logic             res_rdy;
  logic [ACC_W-1:0] res_data;
  logic             res_sat;
  logic             res_ovf;

  modport master (
    output res_vld,
    output res_data,
    output res_sat,
    output res_ovf,
    input  res_rdy
  );

  modport slave (
    input  res_vld,
    input  res_data,
    input  res_sat,
    input  res_ovf,
    output res_rdy
  );

endinterface

// File: rtl/pe_mul_pipe.sv
// pe_mul_pipe: DATA_W x DATA_W multiply with STAGES registers carrying vld/last.
// Ports: a/b/in_vld/in_last in, out_prod/out_vld/out_last out, flush, busy.
module pe_mul_pipe
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int SIGNED = 1,
  parameter int STAGES = PE_MUL_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_vld,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                out_vld,
  output logic                out_last,
  output logic [2*DATA_W-1:0] out_prod,
  output logic                busy
);

  localparam int PW = 2 * DATA_W;

  logic          sa;
  logic          sb;
  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] prod;

  pe_tag_t       tag_q  [STAGES];
  logic [PW-1:0] prod_q [STAGES];

  // Extending to PW first makes the low PW bits of the
  // product correct for both signed and unsigned operands.
  assign sa   = (SIGNED != 0) && a[DATA_W-1];
  assign sb   = (SIGNED != 0) && b[DATA_W-1];
  assign a_x  = {{DATA_W{sa}}, a};
  assign b_x  = {{DATA_W{sb}}, b};
  assign prod = a_x * b_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i]  <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      tag_q[0].vld  <= in_vld & ~flush;
      tag_q[0].last <= in_last;
      prod_q[0]     <= prod;
      for (int i = 1; i < STAGES; i++) begin
        tag_q[i].vld  <= tag_q[i-1].vld & ~flush;
        tag_q[i].last <= tag_q[i-1].last;
        prod_q[i]     <= prod_q[i-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      busy = busy | tag_q[i].vld;
    end
  end

  assign out_vld  = tag_q[STAGES-1].vld;
  assign out_last = tag_q[STAGES-1].last;
  assign out_prod = prod_q[STAGES-1];

endmodule

// File: rtl/pe_mac.sv
// pe_mac: systolic MAC PE; forwards in0/in1 to out0/out1, accumulates
// tagged dot products, result via res (pe_mac_if.master), pe_doing busy.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W     = PE_DATA_W,
  parameter int ACC_W      = PE_ACC_W,
  parameter int SIGNED     = 1,
  parameter int SAT        = 1,
  parameter int MUL_STAGES = PE_MUL_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_vld,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_vld,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              pe_en,
  input  logic              acc_clr,
  output logic              out0_vld,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_vld,
  output logic [DATA_W-1:0] out1_data,
  pe_mac_if.master          res,
  output logic              pe_doing
);

  localparam int PW = 2 * DATA_W;
  localparam int XW = ACC_W + 2;

  logic             accept;
  logic             fin_vld;
  logic             fin_last;
  logic [PW-1:0]    fin_prod;
  logic             pipe_busy;

  logic [ACC_W-1:0] acc_q;
  logic             sat_q;
  logic             part_q;

  logic             acc_s;
  logic             prod_s;
  logic [XW-1:0]    acc_x;
  logic [XW-1:0]    prod_x;
  logic [XW-1:0]    sum_x;
  logic [ACC_W-1:0] nxt;
  logic             hit;
  logic             wr;

  logic             vld_q;
  logic [ACC_W-1:0] data_q;
  logic             rsat_q;
  logic             ovf_q;

  assign accept = in0_vld & in1_vld & pe_en & ~acc_clr;

  pe_mul_pipe #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED),
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (acc_clr),
    .in_vld   (accept),
    .in_last  (in0_last),
    .a        (in0_data),
    .b        (in1_data),
    .out_vld  (fin_vld),
    .out_last (fin_last),
    .out_prod (fin_prod),
    .busy     (pipe_busy)
  );

  // Two guard bits hold any acc+product without loss,
  // so range checks below are exact.
  assign acc_s  = (SIGNED != 0) && acc_q[ACC_W-1];
  assign prod_s = (SIGNED != 0) && fin_prod[PW-1];
  assign acc_x  = {{2{acc_s}}, acc_q};
  assign prod_x = {{(XW-PW){prod_s}}, fin_prod};
  assign sum_x  = acc_x + prod_x;

  always_comb begin
    nxt = sum_x[ACC_W-1:0];
    hit = 1'b0;
    if (SAT != 0) begin
      if (SIGNED != 0) begin
        if (sum_x[XW-1:ACC_W-1] != 3'b000 &&
            sum_x[XW-1:ACC_W-1] != 3'b111) begin
          hit = 1'b1;
          nxt = sum_x[XW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else if (sum_x[ACC_W]) begin
        hit = 1'b1;
        nxt = '1;
      end
    end
  end

  assign wr = fin_vld & fin_last & ~acc_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sat_q  <= 1'b0;
      part_q <= 1'b0;
    end else if (acc_clr) begin
      acc_q  <= '0;
      sat_q  <= 1'b0;
      part_q <= 1'b0;
    end else if (fin_vld) begin
      if (fin_last) begin
        acc_q  <= '0;
        sat_q  <= 1'b0;
        part_q <= 1'b0;
      end else begin
        acc_q  <= nxt;
        sat_q  <= sat_q | hit;
        part_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      rsat_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr) begin
        vld_q  <= 1'b1;
        data_q <= nxt;
        rsat_q <= sat_q | hit;
      end else if (res.res_rdy) begin
        vld_q  <= 1'b0;
      end
      if (acc_clr) begin
        ovf_q <= 1'b0;
      end else if (wr && vld_q && !res.res_rdy) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign res.res_vld  = vld_q;
  assign res.res_data = data_q;
  assign res.res_sat  = rsat_q;
  assign res.res_ovf  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_vld  <= 1'b0;
      out0_data <= '0;
      out0_last <= 1'b0;
      out1_vld  <= 1'b0;
      out1_data <= '0;
    end else begin
      out0_vld <= in0_vld;
      out1_vld <= in1_vld;
      if (in0_vld) begin
        out0_data <= in0_data;
        out0_last <= in0_last;
      end
      if (in1_vld) begin
        out1_data <= in1_data;
      end
    end
  end

  assign pe_doing = pipe_busy | part_q;

endmodule

// File: tb/tb_pe_mac.sv
// tb_pe_mac: directed bench for a signed/saturating 16-bit PE and an
// unsigned 32-bit PE driven by the same operand stream.
module tb_pe_mac;

  typedef struct {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in0_vld = 1'b0;
  logic [7:0] in0_data = '0;
  logic       in0_last = 1'b0;
  logic       in1_vld = 1'b0;
  logic [7:0] in1_data = '0;
  logic       pe_en = 1'b1;
  logic       acc_clr = 1'b0;
  logic       res_rdy = 1'b1;

  logic       s_o0_vld, s_o0_last, s_o1_vld, s_doing;
  logic [7:0] s_o0_data, s_o1_data;
  logic       u_o0_vld, u_o0_last, u_o1_vld, u_doing;
  logic [7:0] u_o0_data, u_o1_data;

  int n_chk = 0;
  int n_err = 0;
  exp_t q_s[$];
  exp_t q_u[$];

  always #5 clk = ~clk;

  pe_mac_if #(.ACC_W(16)) s_if ();
  pe_mac_if #(.ACC_W(32)) u_if ();

  assign s_if.res_rdy = res_rdy;
  assign u_if.res_rdy = res_rdy;

  pe_mac #(
    .DATA_W(8), .ACC_W(16), .SIGNED(1),
    .SAT(1), .MUL_STAGES(2)
  ) u_sgn (
    .clk(clk), .rst_n(rst_n),
    .in0_vld(in0_vld), .in0_data(in0_data),
    .in0_last(in0_last),
    .in1_vld(in1_vld), .in1_data(in1_data),
    .pe_en(pe_en), .acc_clr(acc_clr),
    .out0_vld(s_o0_vld), .out0_data(s_o0_data),
    .out0_last(s_o0_last),
    .out1_vld(s_o1_vld), .out1_data(s_o1_data),
    .res(s_if.master), .pe_doing(s_doing)
  );

  pe_mac #(
    .DATA_W(8), .ACC_W(32), .SIGNED(0),
    .SAT(1), .MUL_STAGES(2)
  ) u_uns (
    .clk(clk), .rst_n(rst_n),
    .in0_vld(in0_vld), .in0_data(in0_data),
    .in0_last(in0_last),
    .in1_vld(in1_vld), .in1_data(in1_data),
    .pe_en(pe_en), .acc_clr(acc_clr),
    .out0_vld(u_o0_vld), .out0_data(u_o0_data),
    .out0_last(u_o0_last),
    .out1_vld(u_o1_vld), .out1_data(u_o1_data),
    .res(u_if.master), .pe_doing(u_doing)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic l);
    in0_vld  = 1'b1;
    in1_vld  = 1'b1;
    in0_data = a;
    in1_data = b;
    in0_last = l;
    step();
  endtask

  task automatic idle();
    in0_vld  = 1'b0;
    in1_vld  = 1'b0;
    in0_last = 1'b0;
  endtask

  task automatic push(input logic [31:0] sd, input logic ss,
                      input logic [31:0] ud, input logic us);
    exp_t e;
    e.data = sd; e.sat = ss; q_s.push_back(e);
    e.data = ud; e.sat = us; q_u.push_back(e);
  endtask

  task automatic wait_res(input string tag);
    int k = 0;
    while (!s_if.res_vld && k < 8) begin
      step();
      k++;
    end
    chk({tag, "_seen"}, 32'(s_if.res_vld), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t es, eu;
    logic have;
    have = (q_s.size() > 0) && (q_u.size() > 0);
    chk({tag, "_queue"}, 32'(have), 32'd1);
    if (have) begin
      es = q_s.pop_front();
      eu = q_u.pop_front();
      chk({tag, "_s_data"}, 32'(s_if.res_data), es.data);
      chk({tag, "_s_sat"}, 32'(s_if.res_sat), 32'(es.sat));
      chk({tag, "_u_data"}, u_if.res_data, eu.data);
      chk({tag, "_u_sat"}, 32'(u_if.res_sat), 32'(eu.sat));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_out0"},
        32'({s_o0_vld, s_o0_data, s_o0_last}), 32'd0);
    chk({tag, "_s_out1"}, 32'({s_o1_vld, s_o1_data}), 32'd0);
    chk({tag, "_s_res"}, 32'({s_if.res_vld, s_if.res_data}), 32'd0);
    chk({tag, "_s_flags"},
        32'({s_if.res_sat, s_if.res_ovf, s_doing}), 32'd0);
    chk({tag, "_u_res"}, u_if.res_data, 32'd0);
    chk({tag, "_u_misc"},
        32'({u_o0_vld, u_o0_data, u_o0_last, u_o1_vld,
             u_o1_data, u_if.res_vld, u_if.res_sat,
             u_if.res_ovf, u_doing}), 32'd0);
  endtask

  initial begin
    // reset state
    step();
    step();
    check_zero("rst");
    rst_n = 1'b1;
    step();

    // unsigned dot product: 3*4 + 5*6 + 7*8 = 98
    push(32'd98, 1'b0, 32'd98, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    chk("dot_doing", 32'(s_doing), 32'd1);
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    idle();
    chk("pt_out0", 32'({s_o0_vld, s_o0_data, s_o0_last}),
        32'({1'b1, 8'd7, 1'b1}));
    chk("pt_out1", 32'({u_o1_vld, u_o1_data}),
        32'({1'b1, 8'd8}));
    chk("lat0", 32'(s_if.res_vld), 32'd0);
    step();
    chk("lat1", 32'(s_if.res_vld), 32'd0);
    step();
    chk("lat2", 32'({s_if.res_vld, u_if.res_vld}), 32'd3);
    pop_check("dot");
    chk("dot_idle", 32'({s_doing, u_doing}), 32'd0);

    // saturation, then back-to-back short sequence
    push(32'h7FFF, 1'b1, 32'd65536, 1'b0);
    push(32'hFFFA, 1'b0, 32'd506, 1'b0);
    send(8'h80, 8'h80, 1'b0);
    send(8'h80, 8'h80, 1'b0);
    send(8'h80, 8'h80, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    send(8'd2, 8'hFD, 1'b1);
    idle();
    wait_res("sat");
    pop_check("sat");
    step();
    chk("b2b_vld", 32'(s_if.res_vld), 32'd1);
    pop_check("b2b");

    // back-pressure and overwrite
    step();
    chk("bp_pre", 32'(s_if.res_vld), 32'd0);
    res_rdy = 1'b0;
    push(32'd9, 1'b0, 32'd9, 1'b0);
    send(8'd2, 8'd2, 1'b1);
    send(8'd3, 8'd3, 1'b1);
    idle();
    step();
    chk("bp_first", 32'({s_if.res_vld, s_if.res_ovf}),
        32'({1'b1, 1'b0}));
    chk("bp_first_data", 32'(s_if.res_data), 32'd4);
    step();
    chk("bp_ovf", 32'({s_if.res_ovf, u_if.res_ovf}), 32'd3);
    pop_check("bp");
    res_rdy = 1'b1;
    step();
    chk("bp_drop", 32'({s_if.res_vld, u_if.res_vld}), 32'd0);
    chk("ovf_sticky", 32'(s_if.res_ovf), 32'd1);

    // pass-through with PE disabled
    pe_en    = 1'b0;
    in0_vld  = 1'b1;
    in0_data = 8'h5A;
    in0_last = 1'b0;
    in1_vld  = 1'b0;
    in1_data = 8'h33;
    step();
    chk("dis_out0", 32'({s_o0_vld, s_o0_data, s_o0_last}),
        32'({1'b1, 8'h5A, 1'b0}));
    chk("dis_out1", 32'({s_o1_vld, s_o1_data}),
        32'({1'b0, 8'd3}));
    chk("dis_doing", 32'({s_doing, u_doing}), 32'd0);
    idle();
    step();
    step();
    step();
    chk("dis_nores", 32'({s_if.res_vld, s_doing}), 32'd0);
    pe_en = 1'b1;

    // acc_clr mid-sequence
    send(8'd9, 8'd9, 1'b0);
    send(8'd4, 8'd4, 1'b0);
    acc_clr = 1'b1;
    send(8'd7, 8'd7, 1'b0);
    acc_clr = 1'b0;
    idle();
    chk("clr_doing", 32'({s_doing, u_doing}), 32'd0);
    chk("clr_ovf", 32'({s_if.res_ovf, u_if.res_ovf}), 32'd0);
    chk("clr_keep", u_if.res_data, 32'd9);
    push(32'd1, 1'b0, 32'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    idle();
    wait_res("clr");
    pop_check("clr");

    // reset mid-sequence
    send(8'd5, 8'd5, 1'b0);
    send(8'd6, 8'd6, 1'b1);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_nores",
          32'({s_if.res_vld, u_if.res_vld, s_doing}), 32'd0);
    end

    chk("q_empty", 32'(q_s.size() + q_u.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
